// File: rtl/eceg_sequencer_if.sv
// Command, arithmetic-unit and response bundle for the ECEG sequencer.
// master is the sequencer side; slave is the system/arithmetic side.
interface eceg_sequencer_if #(
  parameter int unsigned W = 16
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_key;
  logic [W-1:0] cmd_k;
  logic [W-1:0] px;
  logic [W-1:0] py;
  logic [W-1:0] m_x;
  logic [W-1:0] m_y;
  logic [W-1:0] c1_x;
  logic [W-1:0] c1_y;
  logic [W-1:0] c2_x;
  logic [W-1:0] c2_y;

  logic         mul_start;
  logic [W-1:0] mul_n;
  logic [W-1:0] mul_qx;
  logic [W-1:0] mul_qy;
  logic         mul_done;
  logic [W-1:0] mul_rx;
  logic [W-1:0] mul_ry;

  logic         add_start;
  logic [W-1:0] add_ax;
  logic [W-1:0] add_ay;
  logic [W-1:0] add_bx;
  logic [W-1:0] add_by;
  logic         add_done;
  logic [W-1:0] add_rx;
  logic [W-1:0] add_ry;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_op;
  logic         rsp_err;
  logic [W-1:0] r0_x;
  logic [W-1:0] r0_y;
  logic [W-1:0] r1_x;
  logic [W-1:0] r1_y;
  logic         key_loaded;

  modport master (
    input  cmd_valid, cmd_op, cmd_key, cmd_k, px, py, m_x, m_y,
           c1_x, c1_y, c2_x, c2_y,
    output cmd_ready,
    output mul_start, mul_n, mul_qx, mul_qy,
    input  mul_done, mul_rx, mul_ry,
    output add_start, add_ax, add_ay, add_bx, add_by,
    input  add_done, add_rx, add_ry,
    output rsp_valid, rsp_op, rsp_err, r0_x, r0_y, r1_x, r1_y, key_loaded,
    input  rsp_ready
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_key, cmd_k, px, py, m_x, m_y,
           c1_x, c1_y, c2_x, c2_y,
    input  cmd_ready,
    input  mul_start, mul_n, mul_qx, mul_qy,
    output mul_done, mul_rx, mul_ry,
    input  add_start, add_ax, add_ay, add_bx, add_by,
    output add_done, add_rx, add_ry,
    input  rsp_valid, rsp_op, rsp_err, r0_x, r0_y, r1_x, r1_y, key_loaded,
    output rsp_ready
  );
endinterface

// File: rtl/eceg_sequencer.sv
// ECEG keygen/encrypt/decrypt sequencer driving one shared point multiplier
// and one shared point adder; holds the public key Y and the response.
module eceg_sequencer #(
  parameter int unsigned W       = 16,
  parameter int unsigned PRIME   = 17,
  parameter int unsigned TIMEOUT = 1023
) (
  input logic             clk,
  input logic             rst_n,
  eceg_sequencer_if.master bus
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [1:0] OP_KEY = 2'd0;
  localparam logic [1:0] OP_ENC = 2'd1;
  localparam logic [1:0] OP_DEC = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_KEY_MUL, S_ENC_MUL1, S_ENC_MUL2, S_ENC_ADD, S_DEC_MUL, S_DEC_ADD, S_RESP
  } state_t;

  state_t state, state_nxt;
  logic [CW-1:0] wd_cnt;
  logic in_mul, in_add, unit_done, tmo;
  logic [W-1:0] s_neg_y;

  // scalar for later multiplies and the point consumed by the final add (M or C2)
  logic [W-1:0] n_q, n_d, pt_x_q, pt_x_d, pt_y_q, pt_y_d;
  logic [W-1:0] y_x_q, y_x_d, y_y_q, y_y_d;
  logic         key_loaded_q, key_loaded_d, cmd_ready_q, cmd_ready_d;
  logic         mul_start_q, mul_start_d, add_start_q, add_start_d;
  logic [W-1:0] mul_n_q, mul_n_d, mul_qx_q, mul_qx_d, mul_qy_q, mul_qy_d;
  logic [W-1:0] add_ax_q, add_ax_d, add_ay_q, add_ay_d, add_bx_q, add_bx_d, add_by_q, add_by_d;
  logic         rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [1:0]   rsp_op_q, rsp_op_d;
  logic [W-1:0] r0_x_q, r0_x_d, r0_y_q, r0_y_d, r1_x_q, r1_x_d, r1_y_q, r1_y_d;

  assign in_mul    = (state == S_KEY_MUL) || (state == S_ENC_MUL1) ||
                     (state == S_ENC_MUL2) || (state == S_DEC_MUL);
  assign in_add    = (state == S_ENC_ADD) || (state == S_DEC_ADD);
  assign unit_done = (in_mul && bus.mul_done) || (in_add && bus.add_done);
  assign tmo       = (TIMEOUT != 0) && (in_mul || in_add) && !unit_done &&
                     (wd_cnt == CW'(TIMEOUT));
  assign s_neg_y   = (bus.mul_ry == '0) ? '0 : W'(PRIME) - bus.mul_ry;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // next-state: operation order, error shortcuts and watchdog exit
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          case (bus.cmd_op)
            OP_KEY:  state_nxt = S_KEY_MUL;
            OP_ENC:  state_nxt = key_loaded_q ? S_ENC_MUL1 : S_RESP;
            OP_DEC:  state_nxt = S_DEC_MUL;
            default: state_nxt = S_RESP;
          endcase
        end
      end
      S_KEY_MUL:  if (unit_done) state_nxt = S_RESP;
      S_ENC_MUL1: if (unit_done) state_nxt = S_ENC_MUL2;
      S_ENC_MUL2: if (unit_done) state_nxt = S_ENC_ADD;
      S_ENC_ADD:  if (unit_done) state_nxt = S_RESP;
      S_DEC_MUL:  if (unit_done) state_nxt = S_DEC_ADD;
      S_DEC_ADD:  if (unit_done) state_nxt = S_RESP;
      S_RESP:     if (bus.rsp_ready) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
    if (tmo) state_nxt = S_RESP;
  end

  // next values of registered outputs and datapath, launched on each transition
  always_comb begin
    n_d = n_q;  pt_x_d = pt_x_q;  pt_y_d = pt_y_q;
    y_x_d = y_x_q;  y_y_d = y_y_q;  key_loaded_d = key_loaded_q;
    cmd_ready_d = (state_nxt == S_IDLE);
    rsp_valid_d = (state_nxt == S_RESP);
    mul_start_d = 1'b0;  add_start_d = 1'b0;
    mul_n_d = mul_n_q;  mul_qx_d = mul_qx_q;  mul_qy_d = mul_qy_q;
    add_ax_d = add_ax_q;  add_ay_d = add_ay_q;  add_bx_d = add_bx_q;  add_by_d = add_by_q;
    rsp_op_d = rsp_op_q;  rsp_err_d = rsp_err_q;
    r0_x_d = r0_x_q;  r0_y_d = r0_y_q;  r1_x_d = r1_x_q;  r1_y_d = r1_y_q;
    case (state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          rsp_op_d  = bus.cmd_op;
          rsp_err_d = 1'b0;
          r0_x_d = '0;  r0_y_d = '0;  r1_x_d = '0;  r1_y_d = '0;
          n_d    = (bus.cmd_op == OP_ENC) ? bus.cmd_k : bus.cmd_key;
          pt_x_d = (bus.cmd_op == OP_ENC) ? bus.m_x : bus.c2_x;
          pt_y_d = (bus.cmd_op == OP_ENC) ? bus.m_y : bus.c2_y;
          case (bus.cmd_op)
            OP_KEY: begin
              mul_start_d = 1'b1;  mul_n_d = bus.cmd_key;
              mul_qx_d = bus.px;  mul_qy_d = bus.py;
            end
            OP_ENC: begin
              if (key_loaded_q) begin
                mul_start_d = 1'b1;  mul_n_d = bus.cmd_k;
                mul_qx_d = bus.px;  mul_qy_d = bus.py;
              end else begin
                rsp_err_d = 1'b1;
              end
            end
            OP_DEC: begin
              mul_start_d = 1'b1;  mul_n_d = bus.cmd_key;
              mul_qx_d = bus.c1_x;  mul_qy_d = bus.c1_y;
            end
            default: rsp_err_d = 1'b1;
          endcase
        end
      end
      S_KEY_MUL: begin
        if (bus.mul_done) begin
          y_x_d = bus.mul_rx;  y_y_d = bus.mul_ry;  key_loaded_d = 1'b1;
          r0_x_d = bus.mul_rx;  r0_y_d = bus.mul_ry;
        end
      end
      S_ENC_MUL1: begin
        if (bus.mul_done) begin
          r0_x_d = bus.mul_rx;  r0_y_d = bus.mul_ry;
          mul_start_d = 1'b1;  mul_n_d = n_q;  mul_qx_d = y_x_q;  mul_qy_d = y_y_q;
        end
      end
      S_ENC_MUL2: begin
        if (bus.mul_done) begin
          add_start_d = 1'b1;  add_ax_d = pt_x_q;  add_ay_d = pt_y_q;
          add_bx_d = bus.mul_rx;  add_by_d = bus.mul_ry;
        end
      end
      S_ENC_ADD: begin
        if (bus.add_done) begin
          r1_x_d = bus.add_rx;  r1_y_d = bus.add_ry;
        end
      end
      S_DEC_MUL: begin
        if (bus.mul_done) begin
          add_start_d = 1'b1;  add_ax_d = pt_x_q;  add_ay_d = pt_y_q;
          add_bx_d = bus.mul_rx;  add_by_d = s_neg_y;
        end
      end
      S_DEC_ADD: begin
        if (bus.add_done) begin
          r0_x_d = bus.add_rx;  r0_y_d = bus.add_ry;
        end
      end
      default: ;
    endcase
    if (tmo) begin
      rsp_err_d = 1'b1;
      r0_x_d = '0;  r0_y_d = '0;  r1_x_d = '0;  r1_y_d = '0;
    end
  end

  // watchdog: cycles spent in the current wait state, cleared on every state change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  wd_cnt <= '0;
    else if (state_nxt != state) wd_cnt <= '0;
    else if (in_mul || in_add)   wd_cnt <= wd_cnt + CW'(1);
  end

  // output and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q <= '0;  pt_x_q <= '0;  pt_y_q <= '0;  y_x_q <= '0;  y_y_q <= '0;
      key_loaded_q <= 1'b0;  cmd_ready_q <= 1'b1;
      mul_start_q <= 1'b0;  mul_n_q <= '0;  mul_qx_q <= '0;  mul_qy_q <= '0;
      add_start_q <= 1'b0;  add_ax_q <= '0;  add_ay_q <= '0;  add_bx_q <= '0;  add_by_q <= '0;
      rsp_valid_q <= 1'b0;  rsp_op_q <= '0;  rsp_err_q <= 1'b0;
      r0_x_q <= '0;  r0_y_q <= '0;  r1_x_q <= '0;  r1_y_q <= '0;
    end else begin
      n_q <= n_d;  pt_x_q <= pt_x_d;  pt_y_q <= pt_y_d;  y_x_q <= y_x_d;  y_y_q <= y_y_d;
      key_loaded_q <= key_loaded_d;  cmd_ready_q <= cmd_ready_d;
      mul_start_q <= mul_start_d;  mul_n_q <= mul_n_d;  mul_qx_q <= mul_qx_d;  mul_qy_q <= mul_qy_d;
      add_start_q <= add_start_d;  add_ax_q <= add_ax_d;  add_ay_q <= add_ay_d;
      add_bx_q <= add_bx_d;  add_by_q <= add_by_d;
      rsp_valid_q <= rsp_valid_d;  rsp_op_q <= rsp_op_d;  rsp_err_q <= rsp_err_d;
      r0_x_q <= r0_x_d;  r0_y_q <= r0_y_d;  r1_x_q <= r1_x_d;  r1_y_q <= r1_y_d;
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.mul_start  = mul_start_q;
  assign bus.mul_n      = mul_n_q;
  assign bus.mul_qx     = mul_qx_q;
  assign bus.mul_qy     = mul_qy_q;
  assign bus.add_start  = add_start_q;
  assign bus.add_ax     = add_ax_q;
  assign bus.add_ay     = add_ay_q;
  assign bus.add_bx     = add_bx_q;
  assign bus.add_by     = add_by_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_op     = rsp_op_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.r0_x       = r0_x_q;
  assign bus.r0_y       = r0_y_q;
  assign bus.r1_x       = r1_x_q;
  assign bus.r1_y       = r1_y_q;
  assign bus.key_loaded = key_loaded_q;

endmodule

// File: doc/eceg_sequencer.md
Name: eceg_sequencer

Overview:
- Command-driven controller that runs the ECEG operations keygen, encrypt and decrypt on one shared sequential point multiplier and one shared point adder.
- Both arithmetic units sit outside this block; it owns only operand muxing, operation order, the public-key register and the response handshake.
- Sits between the system command interface and the arithmetic units. It replaces the three parallel multiplier instances used by the combinational top level.

Parameters:
- W, 16, coordinate and scalar width in bits.
- PRIME, 17, field modulus used for point negation.
- TIMEOUT, 1023, maximum cycles to wait for any mul_done/add_done; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  2  0=keygen, 1=encrypt, 2=decrypt, 3=reserved
- cmd_key  in  W  secret key (keygen, decrypt)
- cmd_k  in  W  ephemeral scalar (encrypt)
- px, py  in  W each  base point P
- m_x, m_y  in  W each  message point (encrypt)
- c1_x, c1_y, c2_x, c2_y  in  W each  ciphertext (decrypt)
- mul_start  out  1  one-cycle start pulse to multiplier
- mul_n, mul_qx, mul_qy  out  W each  multiplier operands
- mul_done  in  1  one-cycle result-valid pulse
- mul_rx, mul_ry  in  W each  multiplier result
- add_start  out  1  one-cycle start pulse to adder
- add_ax, add_ay, add_bx, add_by  out  W each  adder operands
- add_done  in  1  one-cycle result-valid pulse
- add_rx, add_ry  in  W each  adder result
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_op  out  2  echo of cmd_op
- rsp_err  out  1  error flag
- r0_x, r0_y, r1_x, r1_y  out  W each  result points
- key_loaded  out  1  public-key register valid

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0, except cmd_ready=1. key_loaded=0, Y register=0.
- Command accept: cmd_valid && cmd_ready in IDLE. All cmd_* and point inputs are latched in that cycle. Inputs are don't-care afterwards.
- State machine:
  - IDLE -> KEY_MUL | ENC_MUL1 | DEC_MUL | RESP(err).
  - KEY_MUL: Y = key*P. On done: store Y, key_loaded=1, r0=Y -> RESP.
  - ENC_MUL1: C1 = k*P -> ENC_MUL2.
  - ENC_MUL2: S = k*Y -> ENC_ADD.
  - ENC_ADD: C2 = M+S. r0=C1, r1=C2 -> RESP.
  - DEC_MUL: S = key*C1 -> DEC_ADD.
  - DEC_ADD: M = C2 + (-S). r0=M -> RESP.
  - RESP: rsp_valid=1, held with all r*/rsp_* stable until rsp_ready -> IDLE.
- mul_start / add_start pulse in the first cycle of each MUL/ADD state only. Operands stay stable until the matching done. A done pulse arriving outside the waiting state is ignored.
- Negation: -S = (Sx, Sy==0 ? 0 : PRIME-Sy), computed in W bits. Inputs are assumed < PRIME; no reduction is applied.
- Errors (rsp_err=1, r* = 0, straight to RESP):
  - cmd_op=3.
  - encrypt while key_loaded=0.
  - watchdog: cycles spent in a wait state exceed TIMEOUT. The counter clears on every state entry. The pending unit is abandoned and its late done is ignored.
- A keygen error leaves the existing Y and key_loaded untouched.
- Latency: one cycle from accept to first start. One cycle from the last done to rsp_valid. Zero extra cycles between chained operations (done -> next start in the next cycle).
- A second keygen overwrites Y. Decrypt does not require key_loaded.
- Simultaneous cmd_valid during RESP: not accepted, because cmd_ready=0.
- rsp_ready high in the same cycle rsp_valid rises: completes the transfer, IDLE next cycle.
- Reset mid-operation: immediate return to IDLE, key_loaded=0, start pulses deasserted.

Test Plan:
- Curve y²=x³+2x+2 mod 17, PRIME=17, P=(5,1). Bench uses behavioural mul/add models with 5-cycle latency.
- Keygen key=7 -> exactly one mul_start with n=7, q=(5,1); rsp r0=(0,6), key_loaded=1, rsp_err=0.
- Encrypt k=3, M=(6,3) after keygen -> mul starts with n=3 on (5,1), then n=3 on (0,6); add with a=(6,3), b=(6,3); r0=C1=(10,6), r1=C2=(3,1).
- Decrypt key=7, C1=(10,6), C2=(3,1) -> mul n=7 on (10,6) gives (6,3); add operands a=(3,1), b=(6,14); r0=(6,3).
- Encrypt immediately after reset -> no mul_start; rsp_err=1 after 1 cycle. cmd_op=3 -> same response.
- TIMEOUT=20, mul model never asserts done -> rsp_err=1 at cycle 22 after accept. A late mul_done is ignored; the next keygen completes normally.
- Hold rsp_ready=0 for 10 cycles -> rsp_valid and r* stable, cmd_ready=0. Assert rst_n=0 during ENC_MUL2 -> all outputs 0 and key_loaded=0 asynchronously.
